race_lap_tracker: RTL and testbench
===================================

Name: race_lap_tracker

Overview:
- Per-frame race-progress stage downstream of car physics and upstream of the status-bar digit renderer.
- Samples both cars' world positions once per frame tick and detects forward finish-line crossings, gated by a half-track checkpoint.
- Counts laps per car up to LAP_MAX and declares the winner.
- Lap outputs are single 4-bit digits consumed directly by the bar lap-digit display.

Parameters:
POS_WIDTH, 12, signed two's-complement width of car x/y world coordinates
FINISH_X, -538, finish-line x coordinate; forward direction is decreasing x
FINISH_Y_MIN, -480, lowest y (inclusive) of the finish-line segment
FINISH_Y_MAX, 0, highest y (inclusive) of the finish-line segment
CHECKPOINT_X, 400, a car arms for its next lap once its x >= CHECKPOINT_X
LAP_MAX, 3, laps needed to finish; must be <= 9
DIGIT_WIDTH, 4, width of lap digit outputs

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_tick  in  1  one-cycle strobe, positions valid and stable
i_start  in  1  pulse; starts race from IDLE
i_clear  in  1  pulse; returns to IDLE from any state
i_car1_x  in  POS_WIDTH  car1 x, signed
i_car1_y  in  POS_WIDTH  car1 y, signed
i_car2_x  in  POS_WIDTH  car2 x, signed
i_car2_y  in  POS_WIDTH  car2 y, signed
o_car1_lap  out  DIGIT_WIDTH  car1 completed laps, 0..LAP_MAX
o_car2_lap  out  DIGIT_WIDTH  car2 completed laps, 0..LAP_MAX
o_car1_lap_pulse  out  1  one-cycle pulse on car1 lap increment
o_car2_lap_pulse  out  1  one-cycle pulse on car2 lap increment
o_race_active  out  1  high in RACING
o_race_over  out  1  high in FINISHED
o_winner  out  2  0 none, 1 car1, 2 car2, 3 tie

Behaviour:
- Reset: all outputs 0, global FSM IDLE, both car FSMs IDLE, previous-x registers 0. All outputs registered.
- Global FSM IDLE -> RACING on i_start.
  - Start clears laps and the winner.
  - Start loads prev_x with the current i_carN_x.
  - Both car FSMs go to ARMED.
  - If i_frame_tick coincides with i_start, start wins and the tick is ignored.
- Global FSM RACING -> FINISHED on the tick where any car reaches LAP_MAX laps.
- FINISHED holds until i_clear. i_start is ignored outside IDLE.
- i_clear has highest priority in every state: next cycle is IDLE, laps 0, winner 0, pulses 0.
- Car FSM (per car), evaluated only on i_frame_tick while RACING:
  - ARMED -> HALF when cur_x >= CHECKPOINT_X.
  - HALF -> ARMED on a forward crossing; lap increments and the lap pulse fires.
  - Forward crossing means all of:
    - prev_x > FINISH_X
    - cur_x <= FINISH_X
    - FINISH_Y_MIN <= cur_y <= FINISH_Y_MAX
    - all comparisons signed
  - Reverse crossings and crossings outside the y band have no effect in any state.
  - The first crossing after start (car starts at x=-500 facing 180) is not counted because the car is ARMED.
  - When an increment makes lap == LAP_MAX, the car goes to DONE; DONE ignores all ticks.
- prev_x updates to cur_x on every tick in RACING, regardless of FSM state.
- Winner:
  - First car to reach DONE sets o_winner to 1 or 2.
  - Both cars on the same tick give 3.
  - On the FINISHED transition, the other car freezes at its current lap count.
- Latency: a lap increment, lap pulse and winner all appear on the cycle after the qualifying tick.
- Lap counters saturate at LAP_MAX and never wrap.
- Ticks outside RACING do not update prev_x or the car FSMs.
- Reset asserted mid-race returns everything to reset values immediately (asynchronous).

Optional Feature:
- RACE_LAP_CHECKPOINT_EN defined: checkpoint gating as above (ARMED/HALF).
- Not defined (debug build):
  - HALF state is removed; ARMED counts every forward crossing directly.
  - The first crossing after start therefore counts as lap 1.
  - CHECKPOINT_X is unused.
  - All other behaviour is unchanged.

Test Plan:
1. Reset, i_start with car1 x=-500,y=-300; ticks with x=-520,-540 -> no lap (ARMED), o_car1_lap=0, o_race_active=1. Without the macro, o_car1_lap=1 with one pulse.
2. Car1 tick x=450, then ticks x=-530,-540 at y=-300 -> exactly one o_car1_lap_pulse cycle after the -540 tick; o_car1_lap=1.
3. Car1 checkpoint x=450, then crossing -530 -> -540 at y=+50 (outside band) -> no lap. Then reverse crossing -540 -> -530 -> no lap.
4. Car1 completes 3 laps while car2 is on lap 2 -> o_car1_lap=3, o_winner=1, o_race_over=1. Further car2 crossings leave o_car2_lap=2.
5. Both cars at lap 2 and HALF cross on the same tick -> both laps 3, o_winner=3.
6. i_clear mid-race with laps 1/2 -> next cycle all outputs 0 and IDLE. i_start and i_frame_tick asserted together -> race starts and the tick is ignored.

Source files
------------

// File: rtl/race_lap_tracker.sv
// Per-frame race progress: finish-line crossing detection, per-car lap counting and winner decode.
// Build option: define RACE_LAP_CHECKPOINT_EN to require a half-track checkpoint before each lap counts.
module race_lap_tracker #(
    parameter int          POS_WIDTH    = 12,
    parameter int          FINISH_X     = -538,
    parameter int          FINISH_Y_MIN = -480,
    parameter int          FINISH_Y_MAX = 0,
    parameter int          CHECKPOINT_X = 400,
    parameter int unsigned LAP_MAX      = 3,
    parameter int unsigned DIGIT_WIDTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_frame_tick,
    input  logic                        i_start,
    input  logic                        i_clear,
    input  logic signed [POS_WIDTH-1:0] i_car1_x,
    input  logic signed [POS_WIDTH-1:0] i_car1_y,
    input  logic signed [POS_WIDTH-1:0] i_car2_x,
    input  logic signed [POS_WIDTH-1:0] i_car2_y,
    output logic [DIGIT_WIDTH-1:0]      o_car1_lap,
    output logic [DIGIT_WIDTH-1:0]      o_car2_lap,
    output logic                        o_car1_lap_pulse,
    output logic                        o_car2_lap_pulse,
    output logic                        o_race_active,
    output logic                        o_race_over,
    output logic [1:0]                  o_winner
);

`ifdef RACE_LAP_CHECKPOINT_EN
    localparam bit CKPT_EN = 1'b1;
`else
    localparam bit CKPT_EN = 1'b0;
`endif

    localparam logic [1:0] G_IDLE     = 2'd0;
    localparam logic [1:0] G_RACING   = 2'd1;
    localparam logic [1:0] G_FINISHED = 2'd2;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ARMED = 2'd1;
    localparam logic [1:0] C_HALF  = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    localparam logic signed [POS_WIDTH-1:0] FINISH_X_S = POS_WIDTH'(FINISH_X);
    localparam logic signed [POS_WIDTH-1:0] Y_MIN_S    = POS_WIDTH'(FINISH_Y_MIN);
    localparam logic signed [POS_WIDTH-1:0] Y_MAX_S    = POS_WIDTH'(FINISH_Y_MAX);
    localparam logic signed [POS_WIDTH-1:0] CKPT_X_S   = POS_WIDTH'(CHECKPOINT_X);
    localparam logic [DIGIT_WIDTH-1:0]      LAP_MAX_D  = DIGIT_WIDTH'(LAP_MAX);
    localparam logic [DIGIT_WIDTH-1:0]      LAP_ONE    = DIGIT_WIDTH'(1);

    logic signed [POS_WIDTH-1:0] cur_x [2];
    logic signed [POS_WIDTH-1:0] cur_y [2];

    logic [1:0]                  state_q, state_d;
    logic [1:0]                  car_q [2];
    logic [1:0]                  car_d [2];
    logic signed [POS_WIDTH-1:0] prev_x_q [2];
    logic signed [POS_WIDTH-1:0] prev_x_d [2];
    logic [DIGIT_WIDTH-1:0]      lap_q [2];
    logic [DIGIT_WIDTH-1:0]      lap_d [2];
    logic [1:0]                  pulse_q, pulse_d;
    logic [1:0]                  winner_q, winner_d;
    logic                        race_active_q, race_active_d;
    logic                        race_over_q, race_over_d;

    logic [1:0] crossing;
    logic [1:0] at_cp;
    logic [1:0] bump;
    logic [1:0] reached;

    assign cur_x[0] = i_car1_x;
    assign cur_x[1] = i_car2_x;
    assign cur_y[0] = i_car1_y;
    assign cur_y[1] = i_car2_y;

    // Forward crossing: previous x ahead of the line, current x on or past it, inside the y band.
    always_comb begin
        crossing = '0;
        at_cp    = '0;
        for (int i = 0; i < 2; i++) begin
            crossing[i] = (prev_x_q[i] > FINISH_X_S) && (cur_x[i] <= FINISH_X_S) &&
                          (cur_y[i] >= Y_MIN_S) && (cur_y[i] <= Y_MAX_S);
            at_cp[i]    = (cur_x[i] >= CKPT_X_S);
        end
    end

    always_comb begin
        state_d  = state_q;
        car_d    = car_q;
        prev_x_d = prev_x_q;
        lap_d    = lap_q;
        winner_d = winner_q;
        pulse_d  = '0;
        bump     = '0;
        reached  = '0;
        if (i_clear) begin
            state_d  = G_IDLE;
            winner_d = '0;
            for (int i = 0; i < 2; i++) begin
                car_d[i]    = C_IDLE;
                lap_d[i]    = '0;
                prev_x_d[i] = '0;
            end
        end else begin
            case (state_q)
                G_IDLE: begin
                    if (i_start) begin
                        state_d  = G_RACING;
                        winner_d = '0;
                        for (int i = 0; i < 2; i++) begin
                            car_d[i]    = C_ARMED;
                            lap_d[i]    = '0;
                            prev_x_d[i] = cur_x[i];
                        end
                    end
                end
                G_RACING: begin
                    if (i_frame_tick) begin
                        for (int i = 0; i < 2; i++) begin
                            prev_x_d[i] = cur_x[i];
                            case (car_q[i])
                                C_ARMED: begin
                                    if (CKPT_EN) begin
                                        if (at_cp[i]) car_d[i] = C_HALF;
                                    end else begin
                                        bump[i] = crossing[i];
                                    end
                                end
                                C_HALF:  bump[i] = crossing[i];
                                default: ;
                            endcase
                            // Saturating lap increment; the final lap retires the car.
                            if (bump[i] && (lap_q[i] != LAP_MAX_D)) begin
                                lap_d[i]   = lap_q[i] + LAP_ONE;
                                pulse_d[i] = 1'b1;
                                if ((lap_q[i] + LAP_ONE) == LAP_MAX_D) begin
                                    car_d[i]   = C_DONE;
                                    reached[i] = 1'b1;
                                end else begin
                                    car_d[i] = C_ARMED;
                                end
                            end
                        end
                        // Bit 0 = car1, bit 1 = car2, both = tie.
                        if (reached != 2'b00) begin
                            state_d  = G_FINISHED;
                            winner_d = reached;
                        end
                    end
                end
                default: ;
            endcase
        end
        race_active_d = (state_d == G_RACING);
        race_over_d   = (state_d == G_FINISHED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= G_IDLE;
            pulse_q       <= '0;
            winner_q      <= '0;
            race_active_q <= 1'b0;
            race_over_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                car_q[i]    <= C_IDLE;
                prev_x_q[i] <= '0;
                lap_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            winner_q      <= winner_d;
            race_active_q <= race_active_d;
            race_over_q   <= race_over_d;
            for (int i = 0; i < 2; i++) begin
                car_q[i]    <= car_d[i];
                prev_x_q[i] <= prev_x_d[i];
                lap_q[i]    <= lap_d[i];
            end
        end
    end

    assign o_car1_lap       = lap_q[0];
    assign o_car2_lap       = lap_q[1];
    assign o_car1_lap_pulse = pulse_q[0];
    assign o_car2_lap_pulse = pulse_q[1];
    assign o_race_active    = race_active_q;
    assign o_race_over      = race_over_q;
    assign o_winner         = winner_q;

endmodule

// File: tb/tb_race_lap_tracker.sv
// Scoreboard bench for race_lap_tracker: expected lap-pulse events are queued by the stimulus
// and checked by an independent monitor; static state is checked directly after each step.
module tb_race_lap_tracker;

`ifdef RACE_LAP_CHECKPOINT_EN
    localparam bit CP = 1'b1;
`else
    localparam bit CP = 1'b0;
`endif

    typedef struct packed {
        logic       p1;
        logic       p2;
        logic [3:0] l1;
        logic [3:0] l2;
        logic [1:0] w;
        logic       over;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              start_p = 1'b0;
    logic              clear_p = 1'b0;
    logic signed [11:0] c1x = '0, c1y = '0, c2x = '0, c2y = '0;
    logic [3:0]        car1_lap, car2_lap;
    logic              car1_pulse, car2_pulse, race_active, race_over;
    logic [1:0]        winner;

    int   checks = 0;
    int   errors = 0;
    int   el1;
    exp_t q[$];
    exp_t mon_e;
    exp_t none_e = '0;

    race_lap_tracker dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_frame_tick     (frame_tick),
        .i_start          (start_p),
        .i_clear          (clear_p),
        .i_car1_x         (c1x),
        .i_car1_y         (c1y),
        .i_car2_x         (c2x),
        .i_car2_y         (c2y),
        .o_car1_lap       (car1_lap),
        .o_car2_lap       (car2_lap),
        .o_car1_lap_pulse (car1_pulse),
        .o_car2_lap_pulse (car2_pulse),
        .o_race_active    (race_active),
        .o_race_over      (race_over),
        .o_winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input bit p1, input bit p2, input int l1, input int l2,
                                input int w, input bit over);
        exp_t e;
        e.p1   = p1;
        e.p2   = p2;
        e.l1   = 4'(l1);
        e.l2   = 4'(l2);
        e.w    = 2'(w);
        e.over = over;
        return e;
    endfunction

    // Monitor: every lap pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (car1_pulse || car2_pulse)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%0d%0d expected=none", car1_pulse, car2_pulse);
            end else begin
                mon_e = q.pop_front();
                chk("pulse1", int'(car1_pulse), int'(mon_e.p1));
                chk("pulse2", int'(car2_pulse), int'(mon_e.p2));
                chk("pulse_lap1", int'(car1_lap), int'(mon_e.l1));
                chk("pulse_lap2", int'(car2_lap), int'(mon_e.l2));
                chk("pulse_winner", int'(winner), int'(mon_e.w));
                chk("pulse_over", int'(race_over), int'(mon_e.over));
            end
        end
    end

    task automatic tick(input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        c1x = 12'(x1); c1y = 12'(y1); c2x = 12'(x2); c2y = 12'(y2);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic start_race(input int x1, input int y1, input int x2, input int y2,
                              input bit with_tick);
        @(negedge clk);
        c1x = 12'(x1); c1y = 12'(y1); c2x = 12'(x2); c2y = 12'(y2);
        start_p    = 1'b1;
        frame_tick = with_tick;
        @(negedge clk);
        start_p    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic clear_race();
        @(negedge clk);
        clear_p = 1'b1;
        @(negedge clk);
        clear_p = 1'b0;
    endtask

    // Checkpoint then cross the line at y=-300; parked cars hold their x.
    task automatic seq(input bit m1, input bit m2, input int pk1, input int pk2,
                       input bit push, input exp_t e);
        tick(m1 ? 450 : pk1, -300, m2 ? 450 : pk2, -300);
        tick(m1 ? -530 : pk1, -300, m2 ? -530 : pk2, -300);
        if (push) q.push_back(e);
        tick(m1 ? -540 : pk1, -300, m2 ? -540 : pk2, -300);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lap1"}, int'(car1_lap), 0);
        chk({tag, "_lap2"}, int'(car2_lap), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_active"}, int'(race_active), 0);
        chk({tag, "_over"}, int'(race_over), 0);
        chk({tag, "_pulses"}, int'({car1_pulse, car2_pulse}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: first crossing after start
        start_race(-500, -300, -500, -300, 1'b0);
        chk("t1_active", int'(race_active), 1);
        chk("t1_lap1_start", int'(car1_lap), 0);
        tick(-520, -300, -500, -300);
        if (!CP) q.push_back(mk(1, 0, 1, 0, 0, 0));
        tick(-540, -300, -500, -300);
        el1 = CP ? 0 : 1;
        chk("t1_lap1", int'(car1_lap), el1);
        chk("t1_active_after", int'(race_active), 1);

        // 2: checkpoint then valid crossing
        el1++;
        seq(1'b1, 1'b0, 0, -500, 1'b1, mk(1, 0, el1, 0, 0, 0));
        chk("t2_lap1", int'(car1_lap), el1);
        @(negedge clk);
        chk("t2_pulse_one_cycle", int'(car1_pulse), 0);

        // 3: out-of-band crossing and reverse crossing
        tick(450, -300, -500, -300);
        tick(-530, 50, -500, -300);
        tick(-540, 50, -500, -300);
        chk("t3_out_of_band", int'(car1_lap), el1);
        tick(-530, -300, -500, -300);
        chk("t3_reverse", int'(car1_lap), el1);

        // 4: car1 wins while car2 sits on lap 2
        seq(1'b0, 1'b1, -530, 0, 1'b1, mk(0, 1, el1, 1, 0, 0));
        seq(1'b0, 1'b1, -530, 0, 1'b1, mk(0, 1, el1, 2, 0, 0));
        chk("t4_lap2", int'(car2_lap), 2);
        while (el1 < 3) begin
            el1++;
            seq(1'b1, 1'b0, 0, -540, 1'b1,
                mk(1, 0, el1, 2, (el1 == 3) ? 1 : 0, el1 == 3));
        end
        chk("t4_lap1", int'(car1_lap), 3);
        chk("t4_winner", int'(winner), 1);
        chk("t4_over", int'(race_over), 1);
        chk("t4_active", int'(race_active), 0);
        seq(1'b0, 1'b1, -540, 0, 1'b0, none_e);
        chk("t4_lap2_frozen", int'(car2_lap), 2);
        chk("t4_winner_hold", int'(winner), 1);

        // 5: simultaneous final lap gives a tie
        clear_race();
        chk_all_zero("t5_clear");
        start_race(-500, -300, -500, -300, 1'b0);
        for (int k = 1; k <= 3; k++)
            seq(1'b1, 1'b1, 0, 0, 1'b1, mk(1, 1, k, k, (k == 3) ? 3 : 0, k == 3));
        chk("t5_lap1", int'(car1_lap), 3);
        chk("t5_lap2", int'(car2_lap), 3);
        chk("t5_winner", int'(winner), 3);
        chk("t5_over", int'(race_over), 1);

        // 6: clear mid-race, then start coinciding with a tick
        clear_race();
        start_race(-500, -300, -500, -300, 1'b0);
        seq(1'b1, 1'b0, 0, -500, 1'b1, mk(1, 0, 1, 0, 0, 0));
        seq(1'b0, 1'b1, -540, 0, 1'b1, mk(0, 1, 1, 1, 0, 0));
        seq(1'b0, 1'b1, -540, 0, 1'b1, mk(0, 1, 1, 2, 0, 0));
        chk("t6_lap1", int'(car1_lap), 1);
        chk("t6_lap2", int'(car2_lap), 2);
        clear_race();
        chk_all_zero("t6_clear");
        start_race(450, -300, -500, -300, 1'b1);
        chk("t6_start_active", int'(race_active), 1);
        chk("t6_start_lap1", int'(car1_lap), 0);
        tick(-530, -300, -500, -300);
        if (!CP) q.push_back(mk(1, 0, 1, 0, 0, 0));
        tick(-540, -300, -500, -300);
        chk("t6_tick_ignored", int'(car1_lap), CP ? 0 : 1);

        // Asynchronous reset mid-race
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_active", int'(race_active), 0);
        chk("rst_async_lap1", int'(car1_lap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
